serial_add_sequencer: RTL and testbench

//  Bit-serial adder controller: sequences one full-adder cell (two half_adder

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/full_adder_cell.sv | 43 ++++
 rtl/serial_add_sequencer.sv | 105 ++++++++++
 tb/tb_serial_add_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
// Holds the FSM state encoding and the default operand width.
package serial_add_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sa_state_t;

    localparam int SA_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half adders and an OR of their carries.
// This is the only combinational arithmetic in the serial adder datapath.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: walks one full_adder_cell over WIDTH cycles, LSB first.
// The sum/carry_out registers update only on the completing edge, so partial results never leak out.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic [1:0]       state_dbg
);

    // Handshake: start is sampled only while IDLE or DONE; an accepted start
    // captures a/b on that edge. busy is high for the WIDTH RUN cycles, done is
    // a one-cycle pulse afterwards, and sum/carry_out hold until the next result.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sa_state_t        state;
    sa_state_t        state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last_bit;

    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_bit  = (state == S_RUN) && (cnt == CNT_LAST);
    assign state_dbg = state;

    full_adder_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (cnt == CNT_LAST) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // busy/done come straight from flops so the controller sees clean levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == S_RUN);
            done  <= (state_next == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= 1'b0;
        end else if (state == S_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
            carry  <= fa_c;
            // Counter parks on the terminal value instead of wrapping.
            if (!last_bit) begin
                cnt <= cnt + CW'(1);
            end
            if (last_bit) begin
                sum       <= {fa_s, sum_sh[WIDTH-1:1]};
                carry_out <= fa_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer at WIDTH=16 (directed) and WIDTH=4 (exhaustive).
module tb_serial_add_sequencer;

    logic        clk;
    logic        rst;
    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        carry16;
    logic [1:0]  state16;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        busy4;
    logic        done4;
    logic [3:0]  sum4;
    logic        carry4;
    logic [1:0]  state4;

    logic [16:0] exp16_q[$];
    logic [4:0]  exp4_q[$];

    int n_checks;
    int n_fail;
    int done16_cnt;

    serial_add_sequencer #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .start     (start16),
        .a         (a16),
        .b         (b16),
        .busy      (busy16),
        .done      (done16),
        .sum       (sum16),
        .carry_out (carry16),
        .state_dbg (state16)
    );

    serial_add_sequencer #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start4),
        .a         (a4),
        .b         (b4),
        .busy      (busy4),
        .done      (done4),
        .sum       (sum4),
        .carry_out (carry4),
        .state_dbg (state4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboards: pop on every done pulse
    always @(negedge clk) begin
        if (!rst && done16) begin
            done16_cnt++;
            if (exp16_q.size() == 0) check("sb16_unexpected_done", 32'd1, 32'd0);
            else check("sb16_result", {15'd0, carry16, sum16}, {15'd0, exp16_q.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (!rst && done4) begin
            if (exp4_q.size() == 0) check("sb4_unexpected_done", 32'd1, 32'd0);
            else check("sb4_result", {27'd0, carry4, sum4}, {27'd0, exp4_q.pop_front()});
        end
    end

    // driver: one add on the 16-bit DUT; optional start poke during RUN and
    // optional check that the previous result stays frozen while busy
    task automatic add16(input logic [15:0] a_v, input logic [15:0] b_v,
                         input int poke_cycle, input logic hold_chk, input logic [16:0] hold_val);
        int n;
        int busy_n;
        @(negedge clk);
        a16 = a_v;
        b16 = b_v;
        start16 = 1'b1;
        exp16_q.push_back({1'b0, a_v} + {1'b0, b_v});
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        n = 1;
        busy_n = 0;
        while (!done16 && n < 40) begin
            if (busy16) busy_n++;
            if (hold_chk) check("sum_hold", {15'd0, carry16, sum16}, {15'd0, hold_val});
            if (n == poke_cycle) begin
                start16 = 1'b1;
                a16 = 16'd1;
                b16 = 16'd1;
            end else begin
                start16 = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start16 = 1'b0;
        check("done_latency", n, 17);
        check("busy_cycles", busy_n, 16);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done16}, 32'd0);
        check("idle_after_done", {31'd0, busy16}, 32'd0);
    endtask

    int prev_done;
    int waited;
    int base_cnt;

    initial begin
        n_checks = 0;
        n_fail = 0;
        done16_cnt = 0;
        rst = 1'b1;
        start16 = 1'b0;
        a16 = '0;
        b16 = '0;
        start4 = 1'b0;
        a4 = '0;
        b4 = '0;
        repeat (3) @(negedge clk);

        check("rst_busy", {31'd0, busy16}, 32'd0);
        check("rst_done", {31'd0, done16}, 32'd0);
        check("rst_sum", {16'd0, sum16}, 32'd0);
        check("rst_carry", {31'd0, carry16}, 32'd0);
        check("rst_sum4", {27'd0, carry4, sum4}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        add16(16'd3, 16'd5, 0, 1'b0, 17'd0);
        check("sum_3_5", {15'd0, carry16, sum16}, 32'h0008);

        add16(16'hFFFF, 16'h0001, 0, 1'b0, 17'd0);
        add16(16'h7FFF, 16'h0001, 0, 1'b1, 17'h10000);
        check("sum_7fff_1", {15'd0, carry16, sum16}, 32'h08000);

        // start pulsed mid-RUN must be ignored
        base_cnt = done16_cnt;
        add16(16'd2, 16'd2, 5, 1'b0, 17'd0);
        check("ignored_start_sum", {15'd0, carry16, sum16}, 32'd4);
        repeat (20) @(negedge clk);
        check("ignored_start_pulses", done16_cnt - base_cnt, 1);

        // async reset in the middle of a RUN cycle
        @(negedge clk);
        a16 = 16'h1234;
        b16 = 16'h0F0F;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy16}, 32'd0);
        check("mid_rst_done", {31'd0, done16}, 32'd0);
        check("mid_rst_sum", {15'd0, carry16, sum16}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        base_cnt = done16_cnt;
        repeat (25) @(negedge clk);
        check("no_done_after_rst", done16_cnt - base_cnt, 0);
        add16(16'd10, 16'd20, 0, 1'b0, 17'd0);
        check("sum_after_rst", {15'd0, carry16, sum16}, 32'd30);

        // start held high: back-to-back ops, operands swapped in each DONE cycle
        @(negedge clk);
        a16 = 16'hA5A5;
        b16 = 16'h5A5B;
        start16 = 1'b1;
        exp16_q.push_back({1'b0, a16} + {1'b0, b16});
        prev_done = 0;
        for (int k = 0; k < 3; k++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!done16 && waited < 40);
            check("b2b_period", waited, 17);
            if (k < 2) begin
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                exp16_q.push_back({1'b0, a16} + {1'b0, b16});
            end else begin
                start16 = 1'b0;
            end
        end
        repeat (3) @(negedge clk);

        // WIDTH=4 exhaustive, start held so each DONE cycle loads the next pair
        a4 = 4'd0;
        b4 = 4'd0;
        exp4_q.push_back(5'd0);
        start4 = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!done4 && waited < 20);
            if (waited != 5) check("w4_period", waited, 5);
            if (i < 256) begin
                a4 = 4'(i >> 4);
                b4 = 4'(i);
                exp4_q.push_back({1'b0, a4} + {1'b0, b4});
            end else begin
                start4 = 1'b0;
            end
        end
        repeat (3) @(negedge clk);

        check("sb16_drained", exp16_q.size(), 0);
        check("sb4_drained", exp4_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
